fp_result_log: RTL and testbench

- Downstream consumer of fp_adder on the Basys 3 test top. Captures every (result, flags) pair the adder reports valid into a DEPTH-entry circular log.
- Lets the operator browse past results with debounced buttons and select which 16-bit half goes to the hex display.
- Replaces the single result register so that a sequence of operations can be run and then inspected.

---
 rtl/fp_result_log_pkg.sv | 21 ++
 rtl/fp_result_log_btn_debounce.sv | 50 +++++
 rtl/fp_result_log.sv | 125 ++++++++++++
 tb/tb_fp_result_log.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_result_log_pkg.sv
// Shared definitions for the fp_adder result log: entry layout and field helpers.
package fp_result_log_pkg;

    localparam int FLAGS_W     = 5;
    localparam int RESULT_W    = 32;
    localparam int LOG_ENTRY_W = RESULT_W + FLAGS_W;
    localparam int FLAGS_LSB   = 0;
    localparam int RESULT_LSB  = FLAGS_W;

    // result sits above flags, so the packed layout matches FLAGS_LSB/RESULT_LSB
    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic [FLAGS_W-1:0]  flags;
    } log_entry_t;

    // 16-bit half of an entry's result as shown on the hex display
    function automatic logic [15:0] pick_half(input log_entry_t e, input logic hi);
        return hi ? e.result[31:16] : e.result[15:0];
    endfunction

endpackage

// File: rtl/fp_result_log_btn_debounce.sv
// Raw button conditioning: 2-FF synchroniser, stability counter, rise pulse.
// The synchroniser resets to "pressed" and pulses stay disarmed until a released
// sample is seen, so a button held through reset cannot fire on its way out.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_ext,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             level_d;
    logic             armed;

    // synchronise, count consecutive differing samples, flip level, detect rise
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            sync    <= 2'b11;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            armed   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] != level) begin
                if (cnt == LAST) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            if (!sync[1])
                armed <= 1'b1;
            level_d <= level;
            pulse   <= level & ~level_d & armed;
        end
    end

endmodule

// File: rtl/fp_result_log.sv
// Circular log of fp_adder results with button-driven browsing for the hex display.
module fp_result_log
    import fp_result_log_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int ADDR_W          = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk_ext,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [31:0]       result_in,
    input  logic [4:0]        flags_in,
    input  logic              clear,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_half,
    output logic [15:0]       view_data,
    output logic [4:0]        view_flags,
    output logic [ADDR_W-1:0] view_off,
    output logic              view_half,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] OFF_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);

    log_entry_t        mem [DEPTH];
    log_entry_t        new_entry, rd_entry;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nx, off_cap, off_nx, max_off, rd_addr_nx;
    logic [ADDR_W:0]   count_nx;
    logic              cap, ovf_nx, half_nx;
    logic [15:0]       data_nx;
    logic [4:0]        flags_nx;
    logic              next_p, prev_p, half_p;
    logic              next_lvl, prev_lvl, half_lvl;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
        .clk_ext(clk_ext), .rst(rst), .raw(btn_next), .level(next_lvl), .pulse(next_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_prev (
        .clk_ext(clk_ext), .rst(rst), .raw(btn_prev), .level(prev_lvl), .pulse(prev_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_half (
        .clk_ext(clk_ext), .rst(rst), .raw(btn_half), .level(half_lvl), .pulse(half_p));

    assign new_entry = '{result: result_in, flags: flags_in};
    assign cap       = valid_in & ~clear;
    assign empty     = (count == '0);

    // next-state: clear wins, else capture (with view follow), then browse
    always_comb begin
        wr_ptr_nx = wr_ptr;
        count_nx  = count;
        ovf_nx    = overflow;
        off_cap   = view_off;
        off_nx    = view_off;
        max_off   = '0;
        half_nx   = half_p ? ~view_half : view_half;
        if (clear) begin
            wr_ptr_nx = '0;
            count_nx  = '0;
            ovf_nx    = 1'b0;
            off_nx    = '0;
        end else begin
            if (cap) begin
                wr_ptr_nx = wr_ptr + 1'b1;
                if (count == CNT_MAX)
                    ovf_nx = 1'b1;
                else
                    count_nx = count + 1'b1;
                // keep the same entry in view; clamp once it has been overwritten
                if (view_off != '0 && view_off != OFF_MAX)
                    off_cap = view_off + 1'b1;
            end
            if (count_nx != '0)
                max_off = ADDR_W'(count_nx - 1'b1);
            off_nx = off_cap;
            if (next_p && !prev_p && off_cap != '0)
                off_nx = off_cap - 1'b1;
            else if (prev_p && !next_p && off_cap < max_off)
                off_nx = off_cap + 1'b1;
        end
    end

    // display path from next state, bypassing the entry being written this cycle
    always_comb begin
        rd_addr_nx = wr_ptr_nx - ADDR_W'(1) - off_nx;
        rd_entry   = (cap && rd_addr_nx == wr_ptr) ? new_entry : mem[rd_addr_nx];
        data_nx    = '0;
        flags_nx   = '0;
        if (count_nx != '0) begin
            data_nx  = pick_half(rd_entry, half_nx);
            flags_nx = rd_entry.flags;
        end
    end

    // log storage; contents need no reset since count gates visibility
    always_ff @(posedge clk_ext) begin
        if (cap)
            mem[wr_ptr] <= new_entry;
    end

    // pointer, occupancy, view and registered display outputs
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            view_off   <= '0;
            view_half  <= 1'b0;
            view_data  <= '0;
            view_flags <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nx;
            count      <= count_nx;
            overflow   <= ovf_nx;
            view_off   <= off_nx;
            view_half  <= half_nx;
            view_data  <= data_nx;
            view_flags <= flags_nx;
        end
    end

endmodule

// File: tb/tb_fp_result_log.sv
// Scoreboard bench for fp_result_log: captured entries go into an expected log
// queue (oldest popped on overwrite) and the displayed view is compared against it.
module tb_fp_result_log;

    localparam int DEPTH = 8;
    localparam int ADDR_W = 3;

    logic              clk_ext = 1'b0;
    logic              rst = 1'b1;
    logic              valid_in = 1'b0;
    logic [31:0]       result_in = '0;
    logic [4:0]        flags_in = '0;
    logic              clear = 1'b0;
    logic              btn_next = 1'b0, btn_prev = 1'b0, btn_half = 1'b0;
    logic [15:0]       view_data;
    logic [4:0]        view_flags;
    logic [ADDR_W-1:0] view_off;
    logic              view_half;
    logic [ADDR_W:0]   count;
    logic              empty, overflow;

    int n_chk = 0;
    int n_pass = 0;

    logic [36:0] exp_log[$];
    logic        exp_half = 1'b0;

    fp_result_log #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DEBOUNCE_CYCLES(4)) dut (
        .clk_ext(clk_ext), .rst(rst), .valid_in(valid_in), .result_in(result_in),
        .flags_in(flags_in), .clear(clear), .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_half(btn_half), .view_data(view_data), .view_flags(view_flags),
        .view_off(view_off), .view_half(view_half), .count(count), .empty(empty),
        .overflow(overflow));

    always #5 clk_ext = ~clk_ext;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_ext);
    endtask

    task automatic capture(input logic [31:0] r, input logic [4:0] f);
        valid_in  = 1'b1;
        result_in = r;
        flags_in  = f;
        cycles(1);
        valid_in = 1'b0;
        exp_log.push_back({r, f});
        if (exp_log.size() > DEPTH)
            void'(exp_log.pop_front());
    endtask

    // 0 = next, 1 = prev, 2 = half
    task automatic press(input int which, input int hold);
        case (which)
            0: btn_next = 1'b1;
            1: btn_prev = 1'b1;
            default: btn_half = 1'b1;
        endcase
        cycles(hold);
        case (which)
            0: btn_next = 1'b0;
            1: btn_prev = 1'b0;
            default: btn_half = 1'b0;
        endcase
        cycles(14);
    endtask

    task automatic check_view(input string tag, input int off);
        logic [36:0] e;
        logic [15:0] d;
        logic [4:0]  f;
        d = '0;
        f = '0;
        if (exp_log.size() > off) begin
            e = exp_log[exp_log.size() - 1 - off];
            d = exp_half ? e[36:21] : e[20:5];
            f = e[4:0];
        end
        check({tag, ".off"}, 64'(view_off), 64'(off));
        check({tag, ".data"}, 64'(view_data), 64'(d));
        check({tag, ".flags"}, 64'(view_flags), 64'(f));
    endtask

    initial begin
        cycles(3);
        check("rst.count", 64'(count), 0);
        check("rst.empty", 64'(empty), 1);
        check("rst.ovf", 64'(overflow), 0);
        check("rst.half", 64'(view_half), 0);
        check_view("rst", 0);
        rst = 1'b0;
        cycles(20);

        // three captures, newest on display
        capture(32'h3F800000, 5'h00);
        capture(32'h40000000, 5'h01);
        capture(32'h40400000, 5'h10);
        check("cap3.count", 64'(count), 3);
        check("cap3.empty", 64'(empty), 0);
        check_view("cap3", 0);
        check("cap3.lo", 64'(view_data), 64'h0000);

        press(2, 6);
        exp_half = 1'b1;
        check("half.bit", 64'(view_half), 1);
        check("half.hi", 64'(view_data), 64'h4040);

        // browse with saturation
        press(1, 6);
        check_view("prev1", 1);
        press(1, 6);
        check_view("prev2", 2);
        check("prev2.hi", 64'(view_data), 64'h3F80);
        press(1, 6);
        check_view("prev3.sat", 2);
        for (int i = 0; i < 3; i++) press(0, 6);
        check_view("next3", 0);

        // debounce: glitches ignored, long holds give one pulse
        btn_prev = 1'b1; cycles(1); btn_prev = 1'b0; cycles(1);
        btn_prev = 1'b1; cycles(1); btn_prev = 1'b0; cycles(14);
        check_view("glitch", 0);
        press(1, 100);
        check_view("hold100", 1);
        press(1, 6);
        check_view("hold6", 2);
        press(0, 6);
        check_view("back1", 1);

        // follow: entry B stays in view across a capture
        capture(32'h12345678, 5'h03);
        check_view("follow", 2);
        check("follow.hi", 64'(view_data), 64'h4000);

        // clear beats a same-cycle capture
        clear = 1'b1; valid_in = 1'b1; result_in = 32'hDEADBEEF; flags_in = 5'h1F;
        cycles(1);
        clear = 1'b0; valid_in = 1'b0;
        exp_log.delete();
        check("clr.count", 64'(count), 0);
        check("clr.empty", 64'(empty), 1);
        check("clr.ovf", 64'(overflow), 0);
        check("clr.half", 64'(view_half), 1);
        check_view("clr", 0);

        // overflow with nine then ten captures
        press(2, 6);
        exp_half = 1'b0;
        for (int i = 1; i <= 9; i++) capture(32'(i), 5'(i));
        check("ovf.count", 64'(count), 8);
        check("ovf.flag", 64'(overflow), 1);
        check_view("ovf.new", 0);
        for (int i = 0; i < 8; i++) press(1, 6);
        check_view("ovf.old", 7);
        check("ovf.old.val", 64'(view_data), 2);
        capture(32'd10, 5'd10);
        check_view("ovf.clamp", 7);
        check("ovf.clamp.val", 64'(view_data), 3);

        // reset while next is held: no pulse until a fresh press
        btn_next = 1'b1;
        cycles(10);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        exp_log.delete();
        exp_half = 1'b0;
        check("rst2.count", 64'(count), 0);
        check("rst2.ovf", 64'(overflow), 0);
        check_view("rst2", 0);
        cycles(2);
        capture(32'd11, 5'd1);
        capture(32'd12, 5'd2);
        press(1, 6);
        check_view("rst2.prev", 1);
        cycles(30);
        check_view("rst2.held", 1);
        btn_next = 1'b0;
        cycles(14);
        check_view("rst2.release", 1);
        press(0, 6);
        check_view("rst2.fresh", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
